gray_decoder: RTL and testbench
===============================

# gray_decoder

Receive-side checker for the Gray-code counter. Samples a WIDTH-bit Gray code on qualified cycles, converts it to binary, verifies every step is a legal single-step advance, and flags wrap-around and protocol faults. Sits downstream of the Gray counter's output bus, with `Valid` tied to the counter's `En`.

## Interface
- `WIDTH`, default 3: Gray/binary code width; legal range 2–16.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset; takes priority over every other input in the same cycle.
- `Valid`  in  1  sample strobe; `Gray` is examined only on cycles where `Valid`=1.
- `Gray`  in  WIDTH  Gray-coded count from the counter.
- `Binary`  out  WIDTH  registered binary value of the last accepted code.
- `Locked`  out  1  high once a first code has been accepted.
- `Wrap`  out  1  one-cycle pulse when an accepted step goes from 2^WIDTH−1 to 0.
- `Error`  out  1  sticky fault flag for an illegal step.
- `WrapCnt`  out  8  count of wraps since reset (see Configuration).

## Operation
- Conversion (combinational): b[WIDTH−1] = g[WIDTH−1]; b[i] = b[i+1] ^ g[i] for i = WIDTH−2 down to 0. Call the result `b`, and let `prev` be the current `Binary`.
- FSM states: EMPTY (reset state), TRACK, FAULT.
- EMPTY, `Valid`=1: `Binary` <= `b`, `Locked` <= 1, go to TRACK. No legality check; any code, including nonzero, is accepted. `Wrap` stays 0.
- TRACK, `Valid`=1:
  - `b` == `prev`: hold. No state change, no pulse.
  - `b` == (`prev`+1) mod 2^WIDTH: `Binary` <= `b`. If `prev` == 2^WIDTH−1, assert `Wrap` for this cycle and increment the wrap counter.
  - Any other `b`, including a backward step or multi-bit change: `Error` <= 1, go to FAULT. `Binary` keeps the last good value.
- FAULT: `Valid` and `Gray` are ignored. `Error` and `Binary` hold until `Reset`.
- `Valid`=0 in any state: nothing updates, and `Wrap` returns to 0.
- Increment arithmetic is modulo 2^WIDTH. Compare against a WIDTH-bit wrapped sum, not a WIDTH+1-bit sum.
- Reset values: `Binary`=0, `Locked`=0, `Wrap`=0, `Error`=0, `WrapCnt`=0, state=EMPTY.
- Reset mid-operation (any state): all outputs return to their reset values on the next edge. A `Valid` sample in the reset cycle is discarded.

## Timing
- Latency: one cycle. `Binary`, `Locked`, `Wrap` and `Error` reflect the sample taken at edge N from edge N onward (visible after edge N).
- `Wrap` is high for exactly one cycle per legal wrap step. Back-to-back wraps are impossible when WIDTH ≥ 2.
- `Error` rises on the edge that accepts the illegal sample and never falls except through `Reset`.
- No combinational path from inputs to outputs.

## Configuration
- Macro `GRAY_DEC_WRAPCNT_EN`.
- Defined: `WrapCnt` is an 8-bit counter, incremented on each `Wrap` pulse. It saturates at 255 and never rolls over.
- Undefined: no counter register is built, and `WrapCnt` is tied to 0. All other behaviour is identical.

## Test plan
- WIDTH=3, reset, then `Valid`=1 with codes 000,001,011,010,110,111,101,100,000. Required: `Binary` = 0,1,2,3,4,5,6,7,0; `Wrap`=1 only on the cycle after the last 000; `Error`=0; `WrapCnt`=1 when `GRAY_DEC_WRAPCNT_EN` is defined, 0 when it is not.
- First sample after reset is 110. Required: `Binary`=4, `Locked`=1, no `Error`. Next sample 111 gives `Binary`=5.
- In TRACK with `Binary`=1, present 010 (binary 3). Required: `Error`=1, `Binary` stays 1. A following legal code is ignored and `Error` stays 1.
- Repeat code 011 with `Valid`=1 for 4 cycles, then `Valid`=0 for 3 cycles. Required: `Binary`=2 throughout, `Wrap`=0, `Error`=0.
- Assert `Reset` while in FAULT, and also while `Valid`=1 with a legal code. Required: all outputs 0 and state EMPTY on the next edge; the sample is discarded.
- Define `GRAY_DEC_WRAPCNT_EN` and drive 300 full cycles of codes. Required: `WrapCnt` saturates at 255.

Source files
------------

// File: rtl/gray_decoder.sv
// gray_decoder: receive-side checker for a Gray-code counter bus.
// Converts each qualified Gray sample to binary, tracks single-step advances,
// pulses Wrap on a legal 2^WIDTH-1 -> 0 step and latches Error on any illegal step.
// Optional feature macro: GRAY_DEC_WRAPCNT_EN builds the saturating 8-bit wrap counter;
// without it WrapCnt is tied to zero.
//
// state | meaning
// EMPTY | no code accepted since reset; next valid sample is taken as-is
// TRACK | locked; each valid sample must hold or advance by exactly one
// FAULT | illegal step seen; inputs ignored until Reset
module gray_decoder #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Wrap,
  output logic             Error,
  output logic [7:0]       WrapCnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] inc;
  logic             at_max;
  logic             step_ok;
  logic             wrap_step;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(Gray >> i);
    end
  end

  // Wrapped WIDTH-bit successor of the current value, so 2^WIDTH-1 steps to 0.
  always_comb begin
    inc       = Binary + WIDTH'(1);
    at_max    = &Binary;
    step_ok   = (b == inc);
    wrap_step = (state == TRACK) && Valid && step_ok && at_max;
  end

  // Main FSM with registered outputs; Wrap defaults low so it is a one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= EMPTY;
      Binary <= '0;
      Locked <= 1'b0;
      Wrap   <= 1'b0;
      Error  <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      case (state)
        EMPTY: begin
          if (Valid) begin
            Binary <= b;
            Locked <= 1'b1;
            state  <= TRACK;
          end
        end
        TRACK: begin
          if (Valid && (b != Binary)) begin
            if (step_ok) begin
              Binary <= b;
              Wrap   <= at_max;
            end else begin
              Error <= 1'b1;
              state <= FAULT;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef GRAY_DEC_WRAPCNT_EN
  logic [7:0] wrap_cnt;

  // Saturating wrap counter; holds at 255 rather than rolling over.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrap_cnt <= '0;
    end else if (wrap_step && (wrap_cnt != 8'hFF)) begin
      wrap_cnt <= wrap_cnt + 8'd1;
    end
  end

  assign WrapCnt = wrap_cnt;
`else
  logic unused_wrap_step;

  assign unused_wrap_step = wrap_step;
  assign WrapCnt          = 8'd0;
`endif

endmodule

// File: tb/tb_gray_decoder.sv
// Self-checking bench for gray_decoder: directed scenarios plus randomized
// traffic, compared each cycle against an arithmetic reference model.
module tb_gray_decoder;

  localparam int W = 3;
  localparam int N = 1 << W;
`ifdef GRAY_DEC_WRAPCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         valid;
  logic [W-1:0] gray;
  logic [W-1:0] binary;
  logic         locked;
  logic         wrap;
  logic         error;
  logic [7:0]   wrap_cnt;

  int n_checks;
  int n_fail;

  // reference model state
  int m_bin;
  int m_cnt;
  bit m_locked;
  bit m_wrap;
  bit m_err;

  gray_decoder #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .Valid   (valid),
    .Gray    (gray),
    .Binary  (binary),
    .Locked  (locked),
    .Wrap    (wrap),
    .Error   (error),
    .WrapCnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bin(input int g);
    int r = 0;
    for (int i = 0; i < W; i++) r ^= (g >> i);
    return r & (N - 1);
  endfunction

  function automatic logic [W-1:0] to_gray(input int v);
    int m = v % N;
    return W'(m ^ (m >> 1));
  endfunction

  task automatic model(input bit r, input bit v, input int g);
    int bb;
    if (r) begin
      m_bin = 0; m_cnt = 0; m_locked = 0; m_wrap = 0; m_err = 0;
      return;
    end
    m_wrap = 0;
    if (!v || m_err) return;
    bb = to_bin(g);
    if (!m_locked) begin
      m_bin    = bb;
      m_locked = 1;
    end else if (bb == m_bin) begin
      // hold
    end else if (bb == (m_bin + 1) % N) begin
      if (m_bin == N - 1) begin
        m_wrap = 1;
        if (CNT_EN && m_cnt < 255) m_cnt++;
      end
      m_bin = bb;
    end else begin
      m_err = 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [W-1:0] g);
    @(negedge clk);
    rst   = r;
    valid = v;
    gray  = g;
    @(posedge clk);
    model(r, v, int'(g));
    #1;
    check("binary", int'(binary), m_bin);
    check("locked", int'(locked), int'(m_locked));
    check("wrap", int'(wrap), int'(m_wrap));
    check("error", int'(error), int'(m_err));
    check("wrap_cnt", int'(wrap_cnt), m_cnt);
  endtask

  initial begin
    logic [W-1:0] seq [9];
    int r;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; valid = 1'b0; gray = '0;
    m_bin = 0; m_cnt = 0; m_locked = 0; m_wrap = 0; m_err = 0;

    // reset state
    step(1, 0, 3'b000);
    step(1, 1, 3'b101);

    // full count sequence with one wrap
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    foreach (seq[i]) step(0, 1, seq[i]);
    check("seq_final_bin", int'(binary), 0);
    check("seq_wrap", int'(wrap), 1);
    check("seq_cnt", int'(wrap_cnt), CNT_EN ? 1 : 0);
    step(0, 0, 3'b000);
    check("wrap_pulse_end", int'(wrap), 0);

    // nonzero first sample
    step(1, 0, 3'b000);
    step(0, 1, 3'b110);
    check("first_nonzero", int'(binary), 4);
    step(0, 1, 3'b111);
    check("first_next", int'(binary), 5);

    // illegal jump 1 -> 3, then legal code ignored
    step(1, 0, 3'b000);
    step(0, 1, 3'b000);
    step(0, 1, 3'b001);
    step(0, 1, 3'b010);
    check("jump_err", int'(error), 1);
    check("jump_bin", int'(binary), 1);
    step(0, 1, 3'b011);
    check("fault_hold", int'(binary), 1);
    // reset out of FAULT
    step(1, 1, 3'b001);
    check("fault_reset_err", int'(error), 0);

    // repeated code and idle
    step(0, 1, 3'b000);
    step(0, 1, 3'b001);
    for (int i = 0; i < 4; i++) step(0, 1, 3'b011);
    for (int i = 0; i < 3; i++) step(0, 0, 3'b111);
    check("hold_bin", int'(binary), 2);

    // reset with a legal sample present is discarded
    step(1, 1, 3'b010);
    check("rst_discard_bin", int'(binary), 0);
    check("rst_discard_lock", int'(locked), 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       step(1, 0, W'($urandom));
      else if (r < 5)  step(0, 1, W'($urandom));
      else if (r < 20) step(0, 0, W'($urandom));
      else if (r < 30) step(0, 1, to_gray(m_bin));
      else             step(0, 1, to_gray(m_bin + 1));
    end

    // 300 full cycles to reach counter saturation
    step(1, 0, 3'b000);
    step(0, 1, 3'b000);
    for (int i = 1; i <= 300 * N; i++) step(0, 1, to_gray(i));
    check("cnt_saturate", int'(wrap_cnt), CNT_EN ? 255 : 0);
    check("cnt_no_error", int'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
